// File: rtl/aqfp_alu_pipe.sv
// Pipelined WIDTH-bit ALU with valid/ready ports on both sides and full backpressure.
// Define ALU_PARITY_EN to build the par_a/par_b/par_r datapath; otherwise those ports are tied to 0.
module aqfp_alu_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             par_a,
  output logic             par_b,
  output logic             par_r
);

`ifdef ALU_PARITY_EN
  localparam int PW = WIDTH + 6;
`else
  localparam int PW = WIDTH + 3;
`endif
  localparam int L = STAGES - 1;

  logic [STAGES-1:0] v_q, v_d, load;
  logic [2:0]        op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic              cin_q, cin_d;

  // A slot can take new data if it, or any slot downstream of it, is empty, or the head drains.
  always_comb begin
    logic full_tail;
    full_tail = 1'b1;
    load      = '0;
    for (int i = L; i >= 0; i--) begin
      full_tail = full_tail & v_q[i];
      load[i]   = out_ready | ~full_tail;
    end
  end

  always_comb begin
    v_d    = v_q;
    v_d[0] = load[0] ? in_valid : v_q[0];
    for (int i = 1; i <= L; i++) begin
      v_d[i] = load[i] ? v_q[i-1] : v_q[i];
    end
  end

  always_comb begin
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    cin_d = cin_q;
    if (load[0] && in_valid) begin
      op_d  = op;
      a_d   = a;
      b_d   = b;
      cin_d = cin;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
    end else begin
      v_q   <= v_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      cin_q <= cin_d;
    end
  end

  // ALU on the slot-0 operands; SUB/INC/DEC reuse the adder with an effective B and carry.
  logic [WIDTH-1:0] bx, r_c;
  logic [WIDTH:0]   sum;
  logic             c0, arith, cout_c, ovf_c;
  logic [PW-1:0]    pay_c;

  always_comb begin
    bx    = b_q;
    c0    = 1'b0;
    arith = 1'b1;
    case (op_q)
      3'd0:    c0 = cin_q;
      3'd1:    begin bx = ~b_q; c0 = 1'b1; end
      3'd6:    bx = {{(WIDTH-1){1'b0}}, 1'b1};
      3'd7:    bx = '1;
      default: arith = 1'b0;
    endcase
    sum = {1'b0, a_q} + {1'b0, bx} + {{WIDTH{1'b0}}, c0};
    case (op_q)
      3'd2:    r_c = a_q & b_q;
      3'd3:    r_c = a_q | b_q;
      3'd4:    r_c = a_q ^ b_q;
      3'd5:    r_c = a_q;
      default: r_c = sum[WIDTH-1:0];
    endcase
    cout_c = arith & sum[WIDTH];
    ovf_c  = arith & (a_q[WIDTH-1] == bx[WIDTH-1]) & (r_c[WIDTH-1] != a_q[WIDTH-1]);
`ifdef ALU_PARITY_EN
    pay_c = {^a_q, ^b_q, ^r_c, (r_c == '0), ovf_c, cout_c, r_c};
`else
    pay_c = {(r_c == '0), ovf_c, cout_c, r_c};
`endif
  end

  logic [PW-1:0] pay_out;

  generate
    if (STAGES == 1) begin : g_flat
      assign pay_out = pay_c;
    end else begin : g_pipe
      logic [PW-1:0] pay_q [1:L];
      logic [PW-1:0] pay_d [1:L];

      always_comb begin
        pay_d    = pay_q;
        pay_d[1] = load[1] ? pay_c : pay_q[1];
        for (int i = 2; i <= L; i++) begin
          pay_d[i] = load[i] ? pay_q[i-1] : pay_q[i];
        end
      end

      always_ff @(posedge clk) begin
        pay_q <= pay_d;
      end

      assign pay_out = pay_q[L];
    end
  endgenerate

  // Empty-slot payload is don't-care, so outputs are forced to zero whenever nothing is valid.
  logic [PW-1:0] pay_vis;
  assign out_valid = v_q[L];
  assign pay_vis   = out_valid ? pay_out : '0;
  assign result    = pay_vis[WIDTH-1:0];
  assign cout      = pay_vis[WIDTH];
  assign ovf       = pay_vis[WIDTH+1];
  assign zero      = pay_vis[WIDTH+2];
`ifdef ALU_PARITY_EN
  assign par_r     = pay_vis[WIDTH+3];
  assign par_b     = pay_vis[WIDTH+4];
  assign par_a     = pay_vis[WIDTH+5];
`else
  assign par_r     = 1'b0;
  assign par_b     = 1'b0;
  assign par_a     = 1'b0;
`endif

  assign in_ready = load[0] | ~rst_n;

endmodule

// File: tb/tb_aqfp_alu_pipe.sv
// Self-checking bench for aqfp_alu_pipe: directed cases, backpressure, reset and a randomized scoreboard run.
module tb_aqfp_alu_pipe #(
  parameter int W = 8,
  parameter int S = 2
);

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         o;
    logic         z;
    logic         pa;
    logic         pb;
    logic         pr;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, cin, out_valid, out_ready;
  logic [2:0]   op;
  logic [W-1:0] a, b, result;
  logic         cout, ovf, zero, par_a, par_b, par_r;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  aqfp_alu_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovf(ovf), .zero(zero),
    .par_a(par_a), .par_b(par_b), .par_r(par_r)
  );

  // Reference: unsigned results from plain arithmetic, overflow from the true signed value.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci);
    exp_t         e;
    logic [W:0]   u;
    logic [W+1:0] sx, sy, st, one;
    e   = '0;
    u   = '0;
    st  = '0;
    one = {{(W+1){1'b0}}, 1'b1};
    sx  = {{2{x[W-1]}}, x};
    sy  = {{2{y[W-1]}}, y};
    case (o)
      3'd0: begin
        u   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        e.r = u[W-1:0];
        e.c = u[W];
        st  = sx + sy + {{(W+1){1'b0}}, ci};
      end
      3'd1: begin e.r = x - y; e.c = (x >= y); st = sx - sy; end
      3'd2: e.r = x & y;
      3'd3: e.r = x | y;
      3'd4: e.r = x ^ y;
      3'd5: e.r = x;
      3'd6: begin e.r = x + 1'b1; e.c = (x == '1); st = sx + one; end
      default: begin e.r = x - 1'b1; e.c = (x != '0); st = sx - one; end
    endcase
    e.o = (st[W+1:W-1] != 3'b000) && (st[W+1:W-1] != 3'b111);
    e.z = (e.r == '0);
`ifdef ALU_PARITY_EN
    e.pa = ^x;
    e.pb = ^y;
    e.pr = ^e.r;
`endif
    return e;
  endfunction

  function automatic exp_t observed();
    return {result, cout, ovf, zero, par_a, par_b, par_r};
  endfunction

  // Sends one transaction into an empty pipe with out_ready=1; reports payload and latency in edges.
  task automatic send_one(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, output exp_t got, output int lat);
    got = '0;
    lat = 99;
    op = o; a = x; b = y; cin = ci;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (out_valid) begin
        got = observed();
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    $display("txn op=%0d a=%h b=%h cin=%0d -> result=%h cout=%0d ovf=%0d zero=%0d lat=%0d",
             o, x, y, ci, got.r, got.c, got.o, got.z, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    op = 3'd0; a = '1; b = '1; cin = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || observed() !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: out_valid=%0d outputs=%h in_ready=%0d, want 0/0/1",
               out_valid, observed(), in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    repeat (S + 2) begin @(posedge clk); #1; end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_capture: out_valid=%0d, want 0", out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    exp_t         g;
    int           lat;
    logic [W-1:0] msb, ones, one;
    logic [2:0]   par_exp;
    msb = '0; msb[W-1] = 1'b1;
    ones = '1;
    one = '0; one[0] = 1'b1;

    send_one(3'd0, ones, one, 1'b0, g, lat);
    n_cmp++;
    if (lat !== S || g.r !== '0 || g.c !== 1'b1 || g.z !== 1'b1 || g.o !== 1'b0) begin
      n_fail++;
      $display("FAIL add_wrap: lat=%0d r=%h c=%0d z=%0d o=%0d, want lat=%0d r=0 c=1 z=1 o=0",
               lat, g.r, g.c, g.z, g.o, S);
    end

    send_one(3'd1, msb, one, 1'b1, g, lat);
    n_cmp++;
    if (g.r !== ~msb || g.c !== 1'b1 || g.o !== 1'b1 || g.z !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_ovf: r=%h c=%0d o=%0d z=%0d, want r=%h c=1 o=1 z=0",
               g.r, g.c, g.o, g.z, ~msb);
    end

    send_one(3'd7, '0, one, 1'b0, g, lat);
    n_cmp++;
    if (g.r !== ones || g.c !== 1'b0 || g.o !== 1'b0) begin
      n_fail++;
      $display("FAIL dec_zero: r=%h c=%0d o=%0d, want r=%h c=0 o=0", g.r, g.c, g.o, ones);
    end

`ifdef ALU_PARITY_EN
    par_exp = 3'b101;
`else
    par_exp = 3'b000;
`endif
    send_one(3'd4, W'(7), W'(3), 1'b0, g, lat);
    n_cmp++;
    if (g.r !== W'(4) || {g.pa, g.pb, g.pr} !== par_exp || g.c !== 1'b0 || g.o !== 1'b0) begin
      n_fail++;
      $display("FAIL xor_parity: r=%h par=%b c=%0d o=%0d, want r=04 par=%b c=0 o=0",
               g.r, {g.pa, g.pb, g.pr}, g.c, g.o, par_exp);
    end
  endtask

  task automatic test_backpressure();
    int   sent, rcv, bubble;
    logic acc;
    sent = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < S + 3; cyc++) begin
      in_valid = 1'b1; op = 3'd0; a = W'(sent); b = W'(1); cin = 1'b0;
      @(negedge clk);
      if (cyc >= S + 1) begin
        n_cmp++;
        if (out_valid !== 1'b1 || result !== W'(1)) begin
          n_fail++;
          $display("FAIL bp_hold: out_valid=%0d result=%h, want 1/%h", out_valid, result, W'(1));
        end
      end
      if (in_ready) sent++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++;
    if (sent !== S || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_fill: accepts=%0d in_ready=%0d, want %0d/0", sent, in_ready, S);
    end
    @(posedge clk); #1;

    out_ready = 1'b1;
    rcv = 0;
    bubble = 0;
    for (int cyc = 0; cyc < 40 && rcv < 5; cyc++) begin
      in_valid = (sent < 5);
      a = W'(sent);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid) begin
        n_cmp++;
        if (result !== W'(rcv + 1)) begin
          n_fail++;
          $display("FAIL bp_order: result=%h, want %h", result, W'(rcv + 1));
        end
        $display("txn bp out result=%h", result);
        rcv++;
      end else if (rcv > 0) begin
        bubble++;
      end
      if (acc) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (rcv !== 5 || bubble !== 0) begin
      n_fail++;
      $display("FAIL bp_drain: received=%0d bubbles=%0d, want 5/0", rcv, bubble);
    end
  endtask

  task automatic test_reset_midflight();
    exp_t g;
    int   lat;
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'd0; a = W'(1); b = W'(1); cin = 1'b0;
    @(posedge clk); #1;
    a = W'(2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_in_ready: in_ready=%0d, want 1", in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || observed() !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_flush: out_valid=%0d outputs=%h in_ready=%0d, want 0/0/1",
               out_valid, observed(), in_ready);
    end
    @(posedge clk); #1;
    send_one(3'd0, W'(3), W'(4), 1'b0, g, lat);
    n_cmp++;
    if (lat !== S || g.r !== W'(7)) begin
      n_fail++;
      $display("FAIL rst_first_txn: lat=%0d r=%h, want %0d/%h", lat, g.r, S, W'(7));
    end
  endtask

  task automatic test_random();
    exp_t        q[$];
    exp_t        held, obs, e;
    logic        held_valid, exp_ir;
    logic [63:0] rnd;
    held_valid = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op  = 3'($urandom_range(0, 7));
      rnd = {$urandom, $urandom};
      a   = rnd[W-1:0];
      rnd = {$urandom, $urandom};
      b   = rnd[W-1:0];
      cin = 1'($urandom_range(0, 1));
      @(negedge clk);
      obs = observed();
      if (held_valid) begin
        n_cmp++;
        if (out_valid !== 1'b1 || obs !== held) begin
          n_fail++;
          $display("FAIL rnd_stall: out_valid=%0d outputs=%h, want 1/%h", out_valid, obs, held);
        end
      end
      exp_ir = (q.size() < S) || out_ready;
      n_cmp++;
      if (in_ready !== exp_ir) begin
        n_fail++;
        $display("FAIL rnd_in_ready: in_ready=%0d, want %0d (occupancy %0d)", in_ready, exp_ir, q.size());
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_spurious: got %h, want no output", obs);
        end else begin
          e = q.pop_front();
          if (obs !== e) begin
            n_fail++;
            $display("FAIL rnd_data: got %h, want %h", obs, e);
          end
        end
        $display("txn rnd out result=%h cout=%0d ovf=%0d zero=%0d", result, cout, ovf, zero);
      end
      held_valid = out_valid && !out_ready;
      held = obs;
      if (in_valid && in_ready) q.push_back(model(op, a, b, cin));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < S + 4; k++) begin
      @(negedge clk);
      if (out_valid) begin
        obs = observed();
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_spurious: got %h, want no output", obs);
        end else begin
          e = q.pop_front();
          if (obs !== e) begin
            n_fail++;
            $display("FAIL rnd_data: got %h, want %h", obs, e);
          end
        end
        $display("txn rnd drain result=%h", result);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL rnd_lost: %0d transactions outstanding, want 0", q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0; cin = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
